rtp_tx_scheduler: RTL and testbench

RTP_TX_SCHEDULER -- requirements
Module: rtp_tx_scheduler

---
 rtl/rtp_tx_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_rtp_tx_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rtp_tx_scheduler
// Purpose  : Two-channel round-robin RTP packetiser. It builds the 12-byte RTP
//            header for the granted channel, then streams that channel's
//            payload bytes. Sequence number, timestamp and first-packet
//            marker state are tracked per channel.
// Revision : 1.0 - initial release
// ============================================================================
module rtp_tx_scheduler #(
  parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
  parameter logic [31:0] SSRC0            = 32'h12345678,
  parameter logic [31:0] SSRC1            = 32'h12345679,
  parameter int unsigned PAYLOAD_BYTES    = 948,
  parameter int unsigned TS_INCR          = 474
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  output logic        ch0_gnt,
  output logic        ch0_rd_en,
  input  logic [7:0]  ch0_rd_data,
  input  logic        ch1_req,
  output logic        ch1_gnt,
  output logic        ch1_rd_en,
  input  logic [7:0]  ch1_rd_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic [15:0] udp_send_data_length
);

  localparam logic [15:0] C_LAST_PAY = 16'(PAYLOAD_BYTES - 1);
  localparam logic [31:0] C_TS_INCR  = 32'(TS_INCR);
  localparam logic [3:0]  C_LAST_HDR = 4'd11;
  localparam logic [15:0] C_UDP_LEN  = 16'(PAYLOAD_BYTES + 12);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;       // granted channel of the current packet
  logic        last_q, last_d;     // channel granted by the previous packet
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] seq0_q, seq0_d, seq1_q, seq1_d;
  logic [31:0] ts0_q, ts0_d, ts1_q, ts1_d;
  logic [1:0]  first_q, first_d;   // per-channel "no packet sent yet" flag

  logic        w_xfer;
  logic        w_pay_last;
  logic        w_sel_first;
  logic [15:0] w_sel_seq;
  logic [31:0] w_sel_ts;
  logic [31:0] w_sel_ssrc;
  logic [95:0] w_hdr;
  logic [95:0] w_hdr_sh;
  logic [7:0]  w_hdr_byte;

  assign udp_send_data_length = C_UDP_LEN;

  // Grant is owned from HEADER through DONE; only one channel can be selected.
  assign ch0_gnt  = (state_q != ST_IDLE) & ~sel_q;
  assign ch1_gnt  = (state_q != ST_IDLE) &  sel_q;
  assign tx_valid = (state_q == ST_HEADER) | (state_q == ST_PAYLOAD);
  assign w_xfer   = tx_valid & tx_ready;
  assign w_pay_last = (pay_cnt_q == C_LAST_PAY);

  // Assemble the header of the granted channel and pick the current byte.
  always_comb begin
    w_sel_first = sel_q ? first_q[1] : first_q[0];
    w_sel_seq   = sel_q ? seq1_q : seq0_q;
    w_sel_ts    = sel_q ? ts1_q  : ts0_q;
    w_sel_ssrc  = sel_q ? SSRC1  : SSRC0;
    // Marker bit (byte 1, bit 7) is forced on the first packet of a channel.
    w_hdr = {RTP_HEADER_PARAM[15:8],
             RTP_HEADER_PARAM[7] | w_sel_first, RTP_HEADER_PARAM[6:0],
             w_sel_seq, w_sel_ts, w_sel_ssrc};
    w_hdr_sh   = w_hdr << {hdr_cnt_q, 3'b000};
    w_hdr_byte = w_hdr_sh[95:88];
  end

  // Next-state, datapath update and output decode of the packet FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    seq0_d    = seq0_q;
    seq1_d    = seq1_q;
    ts0_d     = ts0_q;
    ts1_d     = ts1_q;
    first_d   = first_q;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    ch0_rd_en = 1'b0;
    ch1_rd_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ch0_req | ch1_req) begin
          // On a tie the channel that did not win last time is served.
          sel_d     = (ch0_req & ch1_req) ? ~last_q : ch1_req;
          hdr_cnt_d = 4'd0;
          state_d   = ST_HEADER;
        end
      end
      ST_HEADER: begin
        tx_data = w_hdr_byte;
        if (w_xfer) begin
          if (hdr_cnt_q == C_LAST_HDR) begin
            pay_cnt_d = 16'd0;
            state_d   = ST_PAYLOAD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        // Show-ahead source: the byte is passed through and popped on transfer.
        tx_data   = sel_q ? ch1_rd_data : ch0_rd_data;
        tx_last   = w_pay_last;
        ch0_rd_en = w_xfer & ~sel_q;
        ch1_rd_en = w_xfer &  sel_q;
        if (w_xfer) begin
          if (w_pay_last) begin
            state_d = ST_DONE;
          end else begin
            pay_cnt_d = pay_cnt_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        if (sel_q) begin
          seq1_d     = seq1_q + 16'd1;
          ts1_d      = ts1_q + C_TS_INCR;
          first_d[1] = 1'b0;
        end else begin
          seq0_d     = seq0_q + 16'd1;
          ts0_d      = ts0_q + C_TS_INCR;
          first_d[0] = 1'b0;
        end
        last_d  = sel_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and per-channel context registers; reset abandons any packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      hdr_cnt_q <= 4'd0;
      pay_cnt_q <= 16'd0;
      seq0_q    <= 16'd0;
      seq1_q    <= 16'd0;
      ts0_q     <= 32'd0;
      ts1_q     <= 32'd0;
      first_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      seq0_q    <= seq0_d;
      seq1_q    <= seq1_d;
      ts0_q     <= ts0_d;
      ts1_q     <= ts1_d;
      first_q   <= first_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtp_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtp_tx_scheduler
// Purpose  : Self-checking bench for rtp_tx_scheduler. Two show-ahead byte
//            sources feed the DUT; a behavioural packet model predicts the
//            grant, every transmitted byte, tx_last and the read pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtp_tx_scheduler;

  // Byte 1 of the fixed header carries M=0, PT=0 so the marker is visible.
  localparam logic [15:0] HDR = 16'h8000;
  localparam logic [31:0] S0  = 32'h12345678;
  localparam logic [31:0] S1  = 32'h12345679;
  localparam int          PB  = 948;
  localparam int          TSI = 474;
  localparam int          PKT = PB + 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch0_req, ch0_gnt, ch0_rd_en;
  logic [7:0]  ch0_rd_data;
  logic        ch1_req, ch1_gnt, ch1_rd_en;
  logic [7:0]  ch1_rd_data;
  logic        tx_valid, tx_ready, tx_last;
  logic [7:0]  tx_data;
  logic [15:0] udp_len;

  always #5 clk = ~clk;

  rtp_tx_scheduler #(
    .RTP_HEADER_PARAM(HDR), .SSRC0(S0), .SSRC1(S1),
    .PAYLOAD_BYTES(PB), .TS_INCR(TSI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_gnt(ch0_gnt), .ch0_rd_en(ch0_rd_en), .ch0_rd_data(ch0_rd_data),
    .ch1_req(ch1_req), .ch1_gnt(ch1_gnt), .ch1_rd_en(ch1_rd_en), .ch1_rd_data(ch1_rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .udp_send_data_length(udp_len)
  );

  // Show-ahead sources: head byte is always presented, pop on rd_en.
  logic [7:0]  mem0 [4096];
  logic [7:0]  mem1 [4096];
  logic [11:0] ptr0 = '0, ptr1 = '0;
  assign ch0_rd_data = mem0[ptr0];
  assign ch1_rd_data = mem1[ptr1];
  always @(posedge clk) begin
    if (ch0_rd_en) ptr0 <= ptr0 + 12'd1;
    if (ch1_rd_en) ptr1 <= ptr1 + 12'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model state per channel.
  logic [15:0] m_seq [2];
  logic [31:0] m_ts  [2];
  bit          m_first [2];
  bit          m_last;
  logic [11:0] m_ptr [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_seq[c] = 16'd0; m_ts[c] = 32'd0; m_first[c] = 1'b1;
    end
    m_last = 1'b1;
  endtask

  // Monitor bookkeeping.
  int          phase = 0;   // 0 between packets, 1 in packet, 2 closing cycle
  int          idx = 0, gap = 0, pkt_done = 0, rd_cnt = 0, last_pos = 0;
  bit          cur_ch = 1'b0, have_prev = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  bit          gap_en = 1'b0, rnd_rdy = 1'b0, exp_rd;
  logic [7:0]  prev_data = '0, want_b;
  logic [95:0] exp_hdr, hdr_sh;
  logic [7:0]  obs_hdr [12];
  logic [7:0]  last_hdr [12];
  int          glog [$];
  int          slog [$];

  // Observe the DUT on the falling edge and compare with the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; gap = 0; have_prev = 1'b0; prev_stall = 1'b0;
    end else begin
      check("gnt_onehot", 32'(ch0_gnt & ch1_gnt), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
        check("stall_last", 32'(tx_last), 32'(prev_last));
      end
      if (phase == 0) begin
        if (ch0_gnt | ch1_gnt) begin
          cur_ch = (ch0_req && ch1_req) ? ~m_last : ch1_req;
          check("grant", 32'({ch1_gnt, ch0_gnt}), cur_ch ? 32'd2 : 32'd1);
          if (gap_en && have_prev) check("gap", 32'(gap), 32'd2);
          exp_hdr = {HDR[15:8], HDR[7] | m_first[cur_ch], HDR[6:0],
                     m_seq[cur_ch], m_ts[cur_ch], cur_ch ? S1 : S0};
          phase = 1; idx = 0; rd_cnt = 0;
        end else begin
          check("idle_valid", 32'(tx_valid), 32'd0);
          gap++;
        end
      end
      exp_rd = (phase == 1) && (idx >= 12) && tx_valid && tx_ready;
      check("rd_en0", 32'(ch0_rd_en), 32'(exp_rd && !cur_ch));
      check("rd_en1", 32'(ch1_rd_en), 32'(exp_rd && cur_ch));
      if (phase == 1) begin
        check("valid", 32'(tx_valid), 32'd1);
        check("gnt_hold", 32'({ch1_gnt, ch0_gnt}), cur_ch ? 32'd2 : 32'd1);
        if (ch0_rd_en | ch1_rd_en) rd_cnt++;
        if (tx_valid && tx_ready) begin
          if (idx < 12) begin
            hdr_sh = exp_hdr << (8 * idx);
            want_b = hdr_sh[95:88];
            obs_hdr[idx] = tx_data;
          end else begin
            want_b = cur_ch ? mem1[m_ptr[1]] : mem0[m_ptr[0]];
            m_ptr[cur_ch] = m_ptr[cur_ch] + 12'd1;
          end
          check("data", 32'(tx_data), 32'(want_b));
          check("last", 32'(tx_last), 32'(idx == PKT - 1));
          if (tx_last) last_pos = idx + 1;
          idx++;
          if (idx == PKT) phase = 2;
        end
      end else if (phase == 2) begin
        check("done_valid", 32'(tx_valid), 32'd0);
        check("done_gnt", 32'({ch1_gnt, ch0_gnt}), cur_ch ? 32'd2 : 32'd1);
        m_seq[cur_ch]   = m_seq[cur_ch] + 16'd1;
        m_ts[cur_ch]    = m_ts[cur_ch] + 32'(TSI);
        m_first[cur_ch] = 1'b0;
        m_last          = cur_ch;
        last_hdr = obs_hdr;
        glog.push_back(int'(cur_ch));
        slog.push_back(int'({obs_hdr[2], obs_hdr[3]}));
        pkt_done++; have_prev = 1'b1; gap = 1; phase = 0;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  // Downstream ready: always on, or random backpressure when enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_gnt();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = ch0_gnt | ch1_gnt;
    end
    check("gnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_pkts(input int n);
    int target = pkt_done + n;
    for (int i = 0; i < 20000 * n && pkt_done < target; i++) @(posedge clk);
    check("pkt_timeout", 32'(pkt_done >= target), 32'd1);
    #1;
  endtask

  // One packet on channel c; the request is withdrawn right after the grant.
  task automatic send_one(input bit c);
    if (c) ch1_req = 1'b1; else ch0_req = 1'b1;
    wait_gnt();
    @(posedge clk); #1;
    ch0_req = 1'b0; ch1_req = 1'b0;
    wait_pkts(1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] hdr_word(input int b);
    return {last_hdr[b], last_hdr[b+1], last_hdr[b+2], last_hdr[b+3]};
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    m_ptr[0] = '0; m_ptr[1] = '0;
    rst_n = 1'b0; ch0_req = 1'b0; ch1_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_last",  32'(tx_last), 32'd0);
    check("rst_data",  32'(tx_data), 32'd0);
    check("rst_gnt",   32'({ch1_gnt, ch0_gnt}), 32'd0);
    check("rst_rd_en", 32'({ch1_rd_en, ch0_rd_en}), 32'd0);
    check("udp_len",   32'(udp_len), 32'(PKT));
    @(posedge clk); #1 rst_n = 1'b1;

    // First channel 0 packet: marker forced, zero seq/ts.
    send_one(1'b0);
    check("p1_w0", hdr_word(0), 32'h80800000);
    check("p1_w1", hdr_word(4), 32'h00000000);
    check("p1_w2", hdr_word(8), 32'h12345678);
    check("p1_rd_cnt", 32'(rd_cnt), 32'd948);
    check("p1_last_pos", 32'(last_pos), 32'd960);

    // Second channel 0 packet: marker clear, seq 1, ts 474.
    send_one(1'b0);
    check("p2_w0", hdr_word(0), 32'h80000001);
    check("p2_w1", hdr_word(4), 32'h000001DA);

    // Both channels requesting under random backpressure.
    do_reset();
    glog.delete(); slog.delete();
    rnd_rdy = 1'b1; gap_en = 1'b1;
    ch0_req = 1'b1; ch1_req = 1'b1;
    wait_pkts(4);
    ch0_req = 1'b0; ch1_req = 1'b0; gap_en = 1'b0;
    check("rr_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      check("rr_grant", 32'(glog[i]), 32'(i % 2));
      check("rr_seq",   32'(slog[i]), 32'(i / 2));
    end

    // Counter wrap: preload channel 0 seq/ts while idle.
    repeat (2) @(posedge clk);
    force dut.seq0_q = 16'hFFFF;
    force dut.ts0_q  = 32'hFFFFFF00;
    repeat (2) @(posedge clk);
    #1;
    release dut.seq0_q;
    release dut.ts0_q;
    m_seq[0] = 16'hFFFF; m_ts[0] = 32'hFFFFFF00;
    send_one(1'b0);
    check("wrap_pre_seq", 32'({last_hdr[2], last_hdr[3]}), 32'h0000FFFF);
    check("wrap_pre_ts",  hdr_word(4), 32'hFFFFFF00);
    send_one(1'b0);
    check("wrap_seq", 32'({last_hdr[2], last_hdr[3]}), 32'h00000000);
    check("wrap_ts",  hdr_word(4), 32'hFFFFFF00 + 32'(TSI));

    // Reset in the middle of the payload.
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    ch0_req = 1'b1;
    wait_gnt();
    @(posedge clk); #1 ch0_req = 1'b0;
    for (int i = 0; i < 5000 && idx < 312; i++) @(posedge clk);
    check("mid_reached", 32'(idx >= 312), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(tx_valid), 32'd0);
    check("mid_gnt",   32'({ch1_gnt, ch0_gnt}), 32'd0);
    check("mid_rd_en", 32'({ch1_rd_en, ch0_rd_en}), 32'd0);
    check("mid_last",  32'(tx_last), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete(); slog.delete();
    ch0_req = 1'b1; ch1_req = 1'b1;
    wait_pkts(1);
    ch0_req = 1'b0; ch1_req = 1'b0;
    check("post_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFFFFFF, 32'd0);
    check("post_w0", hdr_word(0), 32'h80800000);
    check("post_w1", hdr_word(4), 32'h00000000);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
